// File: rtl/restador4_pkg.sv
// Shared definitions for the restador4 subtractor / down-counter stage.
// Holds the MODO encoding and the default data width.
package restador4_pkg;

    localparam int RESTADOR_WIDTH = 4;

    typedef enum logic [1:0] {
        MODO_HOLD = 2'b00,
        MODO_SUB  = 2'b01,
        MODO_DEC  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_e;

    // Each cell reports both outputs of a full subtractor.
    typedef struct packed {
        logic d;
        logic bout;
    } fs_out_t;

    function automatic fs_out_t full_sub(input logic a, input logic b, input logic bin);
        fs_out_t r;
        r.d    = a ^ b ^ bin;
        r.bout = (~a & b) | (~a & bin) | (b & bin);
        return r;
    endfunction

endpackage

// File: rtl/restador4_completo.sv
// 1-bit full subtractor cell: d = a - b - bin, bout set when the cell borrows.
// A ripple of WIDTH of these forms the restador4 borrow chain.
module restador_completo
    import restador4_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    fs_out_t res;

    always_comb begin
        res  = full_sub(a, b, bin);
        d    = res.d;
        bout = res.bout;
    end

endmodule

// File: rtl/restador4.sv
// Registered 4-bit subtractor / down-counter with a borrow cascade (RBI in, RBO out).
// MODO selects HOLD, SUB (A-B-RBI), DEC (Q-RBI) or LOAD (A), all gated by ENB.
module restador4
    import restador4_pkg::*;
#(
    parameter int WIDTH = RESTADOR_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             RBI,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             ZERO
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rbo_q, rbo_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] op_a, op_b, diff;
    logic [WIDTH:0]   borrow;
    modo_e            modo;

    assign modo = modo_e'(MODO);

    // DEC reuses the subtractor chain as Q - 0 - RBI, so the wrap borrow falls out for free.
    always_comb begin
        op_a = A;
        op_b = B;
        if (modo == MODO_DEC) begin
            op_a = q_q;
            op_b = '0;
        end
    end

    assign borrow[0] = RBI;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        restador_completo u_cell (
            .a    (op_a[i]),
            .b    (op_b[i]),
            .bin  (borrow[i]),
            .d    (diff[i]),
            .bout (borrow[i+1])
        );
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        q_d   = q_q;
        rbo_d = 1'b0;
        if (ENB) begin
            case (modo)
                MODO_SUB,
                MODO_DEC: begin
                    q_d   = diff;
                    rbo_d = borrow[WIDTH];
                end
                MODO_LOAD: q_d = A;
                default:   q_d = q_q;
            endcase
        end
        zero_d = (q_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q    <= '0;
            rbo_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            rbo_q  <= rbo_d;
            zero_q <= zero_d;
        end
    end

    assign Q    = q_q;
    assign RBO  = rbo_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_restador4.sv
// Self-checking bench for restador4: a single stage driven through directed steps
// against a scoreboard, plus a two-stage cascade built from two instances.
module tb_restador4;
    import restador4_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       ENB;
    logic [1:0] MODO;
    logic       RBI;
    logic [3:0] A, B, Q;
    logic       RBO, ZERO;

    // Cascade: LSB ties RBI high, MSB takes the LSB's registered borrow.
    logic       c_enb;
    logic [1:0] c_modo;
    logic [7:0] c_a;
    logic [3:0] lsb_q, msb_q;
    logic       lsb_rbo, msb_rbo, lsb_zero, msb_zero;

    typedef struct packed {
        logic [3:0] q;
        logic       rbo;
        logic       zero;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    tests_run = 0;
    int    fail_cnt  = 0;

    restador4 u_dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .RBI(RBI),
        .A(A), .B(B), .Q(Q), .RBO(RBO), .ZERO(ZERO)
    );

    restador4 u_lsb (
        .CLK(CLK), .RESET(RESET), .ENB(c_enb), .MODO(c_modo), .RBI(1'b1),
        .A(c_a[3:0]), .B(4'h0), .Q(lsb_q), .RBO(lsb_rbo), .ZERO(lsb_zero)
    );

    restador4 u_msb (
        .CLK(CLK), .RESET(RESET), .ENB(c_enb), .MODO(c_modo), .RBI(lsb_rbo),
        .A(c_a[7:4]), .B(4'h0), .Q(msb_q), .RBO(msb_rbo), .ZERO(msb_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one clocked operation, queue its expectation, then compare once the edge has passed.
    task automatic step(input modo_e m, input logic enb, input logic rbi,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic erbo, input logic ezero,
                        input string tag);
        exp_t e;
        string t;
        @(negedge CLK);
        MODO = m;
        ENB  = enb;
        RBI  = rbi;
        A    = a;
        B    = b;
        sb_q.push_back('{q: eq, rbo: erbo, zero: ezero});
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".q"},    {28'd0, Q},    {28'd0, e.q});
        check({t, ".rbo"},  {31'd0, RBO},  {31'd0, e.rbo});
        check({t, ".zero"}, {31'd0, ZERO}, {31'd0, e.zero});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET  = 1'b1;
        ENB    = 1'b0;
        MODO   = MODO_HOLD;
        RBI    = 1'b0;
        A      = 4'h0;
        B      = 4'h0;
        c_enb  = 1'b0;
        c_modo = MODO_HOLD;
        c_a    = 8'h00;

        #1;
        check("reset.q",    {28'd0, Q},    32'h0);
        check("reset.rbo",  {31'd0, RBO},  32'h0);
        check("reset.zero", {31'd0, ZERO}, 32'h1);
        @(negedge CLK);
        RESET = 1'b0;

        // Count to mid-value, then hit the async reset between edges.
        step(MODO_LOAD, 1'b1, 1'b0, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, "load9");
        step(MODO_DEC,  1'b1, 1'b1, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, "dec9");
        @(negedge CLK);
        MODO = MODO_LOAD;
        A    = 4'h5;
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst.q",    {28'd0, Q},    32'h0);
        check("async_rst.rbo",  {31'd0, RBO},  32'h0);
        check("async_rst.zero", {31'd0, ZERO}, 32'h1);
        @(posedge CLK);
        #1;
        check("rst_held.q",    {28'd0, Q},    32'h0);
        check("rst_held.zero", {31'd0, ZERO}, 32'h1);
        @(negedge CLK);
        RESET = 1'b0;

        // Subtraction, including a borrow-out and a borrow-in reaching zero.
        step(MODO_SUB,  1'b1, 1'b0, 4'h7, 4'h2, 4'h5, 1'b0, 1'b0, "sub7m2");
        step(MODO_SUB,  1'b1, 1'b0, 4'h3, 4'h4, 4'hF, 1'b1, 1'b0, "sub3m4");
        step(MODO_HOLD, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, "hold_after_borrow");
        step(MODO_SUB,  1'b1, 1'b1, 4'h4, 4'h3, 4'h0, 1'b0, 1'b1, "sub4m3m1");

        // Down-count through the wrap.
        step(MODO_LOAD, 1'b1, 1'b0, 4'h2, 4'h0, 4'h2, 1'b0, 1'b0, "load2");
        step(MODO_DEC,  1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, "dec_to1");
        step(MODO_DEC,  1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "dec_to0");
        step(MODO_DEC,  1'b1, 1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, "dec_wrap");
        step(MODO_DEC,  1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, "dec_rbi0");

        // Disabled stage: Q holds and any pending borrow is cleared.
        step(MODO_SUB,  1'b1, 1'b0, 4'h0, 4'h1, 4'hF, 1'b1, 1'b0, "sub0m1");
        step(MODO_SUB,  1'b0, 1'b0, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, "enb0_sub");
        step(MODO_LOAD, 1'b0, 1'b0, 4'h3, 4'h0, 4'hF, 1'b0, 1'b0, "enb0_load");
        step(MODO_LOAD, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "load0");
        step(MODO_DEC,  1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "enb0_dec");

        // Back-to-back mode change with no flush.
        step(MODO_LOAD, 1'b1, 1'b0, 4'hC, 4'h0, 4'hC, 1'b0, 1'b0, "loadC");
        step(MODO_SUB,  1'b1, 1'b0, 4'hC, 4'hC, 4'h0, 1'b0, 1'b1, "subCmC");
        step(MODO_HOLD, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "hold_zero");

        check("sb_empty", sb_q.size(), 32'd0);

        // Two-stage cascade: the MSB sees the LSB borrow one edge after the LSB wraps.
        @(negedge CLK);
        c_enb  = 1'b1;
        c_modo = MODO_LOAD;
        c_a    = 8'h10;
        @(posedge CLK);
        #1;
        check("casc_load", {24'd0, msb_q, lsb_q}, 32'h10);
        @(negedge CLK);
        c_modo = MODO_DEC;
        @(posedge CLK);
        #1;
        check("casc_dec1.lsb",     {28'd0, lsb_q},   32'hF);
        check("casc_dec1.lsb_rbo", {31'd0, lsb_rbo}, 32'h1);
        check("casc_dec1.msb",     {28'd0, msb_q},   32'h1);
        @(posedge CLK);
        #1;
        check("casc_dec2",          {24'd0, msb_q, lsb_q}, 32'h0E);
        check("casc_dec2.lsb_rbo",  {31'd0, lsb_rbo},      32'h0);
        check("casc_dec2.msb_rbo",  {31'd0, msb_rbo},      32'h0);
        check("casc_dec2.msb_zero", {31'd0, msb_zero},     32'h1);
        check("casc_dec2.lsb_zero", {31'd0, lsb_zero},     32'h0);
        @(negedge CLK);
        c_modo = MODO_HOLD;

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
